// File: rtl/aes_dec_word_loader.sv
// aes_dec_word_loader: packs 32-bit words into key/ciphertext blocks, feeds the AES decrypt cipher, captures its result onto a 128-bit valid/ready output
module aes_dec_word_loader #(
  parameter int SETTLE_CYCLES = 2,
  parameter int BLKCNT_W      = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_is_key,
  input  logic [31:0]         in_data,
  output logic [127:0]        cipher_datain,
  output logic [127:0]        cipher_key,
  input  logic [127:0]        cipher_dataout,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [127:0]        out_data,
  output logic                key_loaded,
  output logic [BLKCNT_W-1:0] blocks_done
);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  typedef enum logic [1:0] {COLLECT, SETTLE, HOLD} state_t;
  state_t state_q, state_d;
  logic [1:0] key_cnt_q, key_cnt_d, data_cnt_q, data_cnt_d;
  logic [SW-1:0] settle_cnt_q, settle_cnt_d;
  logic [127:0] key_q, key_d, din_q, din_d, out_data_q, out_data_d;
  logic out_valid_q, out_valid_d, key_loaded_q, key_loaded_d;
  logic [BLKCNT_W-1:0] blocks_done_q, blocks_done_d;
  logic key_acc, data_acc;
  assign in_ready = (state_q == COLLECT) && (in_is_key ? data_cnt_q == 2'd0 : key_loaded_q);
  assign key_acc = in_valid && in_ready && in_is_key;
  assign data_acc = in_valid && in_ready && !in_is_key;
  assign cipher_datain = din_q;
  assign cipher_key = key_q;
  assign out_valid = out_valid_q;
  assign out_data = out_data_q;
  assign key_loaded = key_loaded_q;
  assign blocks_done = blocks_done_q;
  always_comb begin
    state_d = state_q;
    key_cnt_d = key_cnt_q;
    data_cnt_d = data_cnt_q;
    settle_cnt_d = settle_cnt_q;
    key_d = key_q;
    din_d = din_q;
    out_data_d = out_data_q;
    out_valid_d = out_valid_q;
    key_loaded_d = key_loaded_q;
    blocks_done_d = blocks_done_q;
    if (key_acc) begin
      key_d = {key_q[95:0], in_data};
      key_cnt_d = key_cnt_q + 2'd1;
      key_loaded_d = (key_cnt_q == 2'd3) ? 1'b1 : (key_cnt_q == 2'd0) ? 1'b0 : key_loaded_q;
    end
    if (data_acc) begin
      din_d = {din_q[95:0], in_data};
      data_cnt_d = data_cnt_q + 2'd1;
      if (data_cnt_q == 2'd3) begin
        state_d = SETTLE;
        settle_cnt_d = SW'(SETTLE_CYCLES - 1);
      end
    end
    if (state_q == SETTLE) begin
      settle_cnt_d = (settle_cnt_q != '0) ? settle_cnt_q - SW'(1) : settle_cnt_q;
      if (settle_cnt_q == '0) begin
        out_data_d = cipher_dataout;
        out_valid_d = 1'b1;
        state_d = HOLD;
      end
    end
    if (state_q == HOLD && out_ready) begin
      out_valid_d = 1'b0;
      blocks_done_d = blocks_done_q + BLKCNT_W'(1);
      state_d = COLLECT;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= COLLECT;
      key_cnt_q <= '0;
      data_cnt_q <= '0;
      settle_cnt_q <= '0;
      key_q <= '0;
      din_q <= '0;
      out_data_q <= '0;
      out_valid_q <= 1'b0;
      key_loaded_q <= 1'b0;
      blocks_done_q <= '0;
    end else begin
      state_q <= state_d;
      key_cnt_q <= key_cnt_d;
      data_cnt_q <= data_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      key_q <= key_d;
      din_q <= din_d;
      out_data_q <= out_data_d;
      out_valid_q <= out_valid_d;
      key_loaded_q <= key_loaded_d;
      blocks_done_q <= blocks_done_d;
    end
  end
endmodule

// File: tb/tb_aes_dec_word_loader.sv
// tb_aes_dec_word_loader: scoreboard bench with a queue-based block model and an xor stand-in for the cipher
module tb_aes_dec_word_loader;
  localparam int S = 2;
  localparam int BW = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0, in_is_key = 1'b0, out_ready = 1'b0;
  logic [31:0] in_data = '0;
  logic in_ready, out_valid, key_loaded;
  logic [127:0] cipher_datain, cipher_key, cipher_dataout, out_data;
  logic [BW-1:0] blocks_done;
  aes_dec_word_loader #(.SETTLE_CYCLES(S), .BLKCNT_W(BW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_is_key(in_is_key),
    .in_data(in_data), .cipher_datain(cipher_datain), .cipher_key(cipher_key),
    .cipher_dataout(cipher_dataout), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .key_loaded(key_loaded), .blocks_done(blocks_done)
  );
  assign cipher_dataout = cipher_datain ^ cipher_key;
  always #5 clk = ~clk;
  typedef struct {logic [127:0] data; int due;} exp_t;
  exp_t q[$];
  logic [31:0] kw[$], dw[$];
  int cyc = 0;
  int n_chk = 0, n_fail = 0;
  logic [BW-1:0] bd = '0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  // model: predict acceptance mid-cycle, apply it just after the edge that sampled it
  initial begin
    logic pred;
    pred = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        kw.delete();
        dw.delete();
        q.delete();
      end else if (in_valid && pred) begin
        if (in_is_key) begin
          if (kw.size() == 4) kw.delete();
          kw.push_back(in_data);
        end else begin
          dw.push_back(in_data);
          if (dw.size() == 4) begin
            q.push_back('{data: {dw[0], dw[1], dw[2], dw[3]} ^ {kw[0], kw[1], kw[2], kw[3]}, due: cyc + S});
            dw.delete();
          end
        end
      end
      #3;
      pred = (q.size() == 0) && (in_is_key ? dw.size() == 0 : kw.size() == 4);
      chk("in_ready", {127'd0, in_ready}, {127'd0, pred});
      chk("key_loaded", {127'd0, key_loaded}, {127'd0, kw.size() == 4});
    end
  end
  // monitor: output timing, data and handshake accounting
  initial begin
    logic ev;
    forever begin
      @(negedge clk);
      ev = (q.size() != 0) && (cyc >= q[0].due);
      chk("out_valid", {127'd0, out_valid}, {127'd0, ev});
      chk("blocks_done", {{(128-BW){1'b0}}, blocks_done}, {{(128-BW){1'b0}}, bd});
      if (ev) chk("out_data", out_data, q[0].data);
      if (rst) bd = '0;
      else if (ev && out_ready) begin
        void'(q.pop_front());
        bd = bd + 1'b1;
      end
    end
  end
  task automatic step(input logic v, input logic k, input logic [31:0] d, input logic r);
    in_valid = v;
    in_is_key = k;
    in_data = d;
    out_ready = r;
    @(posedge clk);
    #2;
  endtask
  initial begin
    logic [31:0] kv[4];
    logic [31:0] dv[4];
    kv = '{32'h00010203, 32'h04050607, 32'h08090a0b, 32'h0c0d0e0f};
    dv = '{32'h0, 32'h0, 32'h0, 32'h000000ff};
    repeat (3) step(0, 0, 0, 0);
    rst = 1'b0;
    chk("rst_out_data", out_data, '0);
    chk("rst_cipher_key", cipher_key, '0);
    chk("rst_cipher_datain", cipher_datain, '0);
    for (int i = 0; i < 4; i++) step(1, 0, $urandom, 1);
    for (int i = 0; i < 4; i++) step(1, 1, kv[i], 0);
    for (int i = 0; i < 4; i++) step(1, 0, dv[i], 0);
    step(0, 0, 0, 0);
    chk("settle_gap", {127'd0, out_valid}, 128'd0);
    step(0, 0, 0, 0);
    chk("first_valid", {127'd0, out_valid}, 128'd1);
    chk("first_data", out_data, 128'h000102030405060708090a0b0c0d0ef0);
    repeat (10) step(1, 1, 32'hdeadbeef, 0);
    chk("hold_data", out_data, 128'h000102030405060708090a0b0c0d0ef0);
    step(0, 0, 0, 1);
    chk("first_count", {{(128-BW){1'b0}}, blocks_done}, 128'd1);
    step(1, 0, 32'ha0a0a0a0, 1);
    step(1, 0, 32'ha1a1a1a1, 1);
    step(1, 1, 32'h11111111, 1);
    step(1, 0, 32'ha2a2a2a2, 1);
    step(1, 0, 32'ha3a3a3a3, 1);
    for (int i = 0; i < 20 && blocks_done != 2; i++) step(0, 0, 0, 1);
    chk("old_key_count", {{(128-BW){1'b0}}, blocks_done}, 128'd2);
    step(1, 1, 32'h11111111, 1);
    chk("new_key_drop", {127'd0, key_loaded}, 128'd0);
    for (int i = 0; i < 3; i++) step(1, 1, $urandom, 1);
    for (int i = 0; i < 4; i++) step(1, 0, $urandom, 1);
    rst = 1'b1;
    step(0, 0, 0, 1);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) step(1, 0, $urandom, 1);
    chk("rst_settle_key", {127'd0, key_loaded}, 128'd0);
    chk("rst_settle_count", {{(128-BW){1'b0}}, blocks_done}, 128'd0);
    for (int i = 0; i < 4; i++) step(1, 1, $urandom, 1);
    for (int i = 0; i < 4; i++) step(1, 0, $urandom, 1);
    for (int i = 0; i < 20 && blocks_done != 1; i++) step(0, 0, 0, 1);
    chk("reload_count", {{(128-BW){1'b0}}, blocks_done}, 128'd1);
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom % 97) == 0;
      step($urandom % 2, ($urandom % 4) == 0, $urandom, $urandom % 2);
    end
    rst = 1'b1;
    step(0, 0, 0, 1);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) step(1, 1, $urandom, 1);
    for (int i = 0; i < 16 * 7; i++) step(1, 0, $urandom, 1);
    for (int i = 0; i < 20 && out_valid; i++) step(0, 0, 0, 1);
    chk("wrap_count", {{(128-BW){1'b0}}, blocks_done}, 128'd0);
    repeat (10) step(0, 0, 0, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
